reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Sequential debug reader for the CPU register file. On a start pulse it walks an address range two registers per fetch, using both read ports (even register on A, odd register on B). It snapshots each pair and streams the values one at a time over a valid/ready output handshake, tagged with the register index. It sits beside the datapath, sharing the register file's read-address muxes when the debug path is selected, and feeds the board display/UART debug stream.

## Interface
Parameters:
- START_REG, 0, first register read; must be even.
- END_REG, 31, last register read; must be odd and greater than START_REG.

Ports:
- clk_W  in  1  clock; the same clock as register-file writes.
- rst_  in  1  reset; asynchronous, active-low.
- start  in  1  begin a dump; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE without done.
- A_addr  out  5  read address to port A; always equals ptr.
- B_addr  out  5  read address to port B; always equals ptr+1.
- A_in  in  32  port A read data (combinational from the file).
- B_in  in  32  port B read data.
- dout_valid  out  1  output word valid.
- dout_ready  in  1  downstream accepts the word.
- dout_data  out  32  register value.
- dout_idx  out  5  register number of dout_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- ptr is a 5-bit register, always even. On start it is loaded with START_REG.
- States:
  - IDLE: start=1 → load ptr=START_REG, go to FETCH.
  - FETCH: A_addr/B_addr present ptr/ptr+1. At the clock edge, capture A_in→buf0 and B_in→buf1, then go to SEND_A.
  - SEND_A: dout_valid=1, dout_data=buf0, dout_idx=ptr. On dout_valid&dout_ready → SEND_B.
  - SEND_B: dout_valid=1, dout_data=buf1, dout_idx=ptr+1. On handshake:
    - if ptr+1==END_REG → DONE;
    - else ptr←ptr+2 → FETCH.
  - DONE: done=1 for one cycle → IDLE.
- The snapshot is per pair. A register write landing after the FETCH edge is not reflected until the next dump.
- A same-edge write to the fetched address is not seen, because the file's write is edge-registered.
- R0 reads as whatever the file returns; there is no special-casing here.
- start while busy is ignored.
- abort has priority over every transition. From any non-IDLE state, abort=1 at a clock edge → IDLE. dout_valid drops, and done does not pulse.
- Handshake rules:
  - dout_data and dout_idx are stable while dout_valid=1 and dout_ready=0.
  - dout_valid never deasserts without a handshake, except on abort or reset.
- ptr arithmetic is 5-bit. END_REG=31 means ptr+1=31, so ptr never wraps.

## Timing
- Reset values:
  - state=IDLE, ptr=START_REG, so A_addr=START_REG and B_addr=START_REG+1;
  - buf0=buf1=0, dout_data=0, dout_idx=0;
  - dout_valid=0, busy=0, done=0.
- Reset mid-dump: immediate asynchronous return to the reset values. No partial done.
- start sampled at edge 0 → FETCH in cycle 1, first dout_valid in cycle 2.
- With dout_ready held high, a pair costs 3 cycles (FETCH, SEND_A, SEND_B).
- Full 0..31 dump with ready high:
  - last word accepted at the end of cycle 48;
  - done high in cycle 49;
  - IDLE in cycle 50.
- dout_ready low stalls SEND_A or SEND_B indefinitely with no loss.

## Structure
- Shared package (cpu_dbg_pkg):
  - state encoding localparams S_IDLE, S_FETCH, S_SEND_A, S_SEND_B, S_DONE;
  - default DUMP_START=0, DUMP_END=31;
  - REG_AW=5, REG_DW=32.
- One natural sub-module, reg_pair_buf: a two-entry capture/hold buffer with a load strobe and a select input. The FSM, ptr counter and handshake stay in the top.

## Test plan
All scenarios run against the CPU register file after reset: R0=0, R7=7, R8=f7f7_f7f7, R9=37f7_f7f7, R29=8000_0002, R30=ffff_ffff, R31=7fff_ffff, all others 1.
- Full dump, ready high → 32 words, idx 0..31, values as listed; done in cycle 49; busy low from cycle 50.
- Random dout_ready (50%) → same 32 idx/value pairs in order; data and idx stable during every stall; no duplicates or drops.
- Write R9←1234_5678 during the SEND_A cycle of pair 8/9 → dump outputs R9=37f7_f7f7; a second dump outputs 1234_5678.
- abort asserted in SEND_B of pair 4/5 → IDLE next cycle, dout_valid=0, no done; a subsequent start restarts at idx 0.
- rst_ low mid-dump (ready held low in SEND_A) → all outputs return to reset values asynchronously; start during busy is ignored (idx sequence unaffected).
- START_REG=28, END_REG=31 → words 28..31 = 1, 8000_0002, ffff_ffff, 7fff_ffff; done in cycle 7.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg
//   Shared definitions for the CPU debug path: register-file geometry,
//   default dump range and the dump-reader state encoding.
package cpu_dbg_pkg;

  localparam int REG_AW     = 5;
  localparam int REG_DW     = 32;
  localparam int DUMP_START = 0;
  localparam int DUMP_END   = 31;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SEND_A = 3'd2,
    S_SEND_B = 3'd3,
    S_DONE   = 3'd4
  } dump_state_e;

endpackage

// File: rtl/reg_pair_buf.sv
// reg_pair_buf
//   Two-entry capture/hold buffer for one even/odd register pair.
//   Ports:
//     clk_W, rst_   clock, asynchronous active-low reset (entries clear to 0)
//     load_i        capture d0_i/d1_i at the clock edge
//     sel_i         0 presents entry 0, 1 presents entry 1 on q_o
//     d0_i, d1_i    data to capture (port A / port B read data)
//     q_o           selected entry
module reg_pair_buf
  import cpu_dbg_pkg::*;
(
  input  logic              clk_W,
  input  logic              rst_,
  input  logic              load_i,
  input  logic              sel_i,
  input  logic [REG_DW-1:0] d0_i,
  input  logic [REG_DW-1:0] d1_i,
  output logic [REG_DW-1:0] q_o
);

  logic [REG_DW-1:0] buf0_q;
  logic [REG_DW-1:0] buf1_q;

  always_ff @(posedge clk_W or negedge rst_) begin
    if (!rst_) begin
      buf0_q <= '0;
      buf1_q <= '0;
    end else if (load_i) begin
      buf0_q <= d0_i;
      buf1_q <= d1_i;
    end
  end

  assign q_o = sel_i ? buf1_q : buf0_q;

endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Walks register range START_REG..END_REG two registers per fetch (even on
//   read port A, odd on port B), snapshots each pair and streams the words
//   one at a time, tagged with their register index.
//   Ports:
//     clk_W, rst_          clock, asynchronous active-low reset
//     start                begin a dump (only honoured in IDLE)
//     abort                synchronous cancel back to IDLE, no done pulse
//     A_addr, B_addr       read addresses: ptr and ptr+1
//     A_in, B_in           read data from the register file
//     dout_valid/ready     output handshake
//     dout_data, dout_idx  register value and its index
//     busy                 high whenever not IDLE
//     done                 one-cycle pulse after the last word is accepted
//     dbg_state_o          current FSM state
//
//   Output handshake: a word transfers on a clock edge where dout_valid and
//   dout_ready are both high. Once dout_valid rises, dout_valid, dout_data
//   and dout_idx hold until that transfer; only abort or reset withdraw them.
module reg_dump_reader
  import cpu_dbg_pkg::*;
#(
  parameter int START_REG = DUMP_START,
  parameter int END_REG   = DUMP_END
) (
  input  logic              clk_W,
  input  logic              rst_,
  input  logic              start,
  input  logic              abort,
  output logic [REG_AW-1:0] A_addr,
  output logic [REG_AW-1:0] B_addr,
  input  logic [REG_DW-1:0] A_in,
  input  logic [REG_DW-1:0] B_in,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [REG_DW-1:0] dout_data,
  output logic [REG_AW-1:0] dout_idx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state_o
);

  localparam logic [REG_AW-1:0] START_P = REG_AW'(START_REG);
  localparam logic [REG_AW-1:0] END_P   = REG_AW'(END_REG);

  dump_state_e       state_q;
  logic [REG_AW-1:0] ptr_q;
  logic [REG_AW-1:0] ptr_odd;
  logic [REG_AW-1:0] ptr_d;
  logic [REG_AW-1:0] idx_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  // ptr is always even, so ptr+1 never carries and END_REG=31 never wraps.
  assign ptr_odd = ptr_q + 5'd1;
  assign ptr_d   = ptr_q + 5'd2;

  assign A_addr = ptr_q;
  assign B_addr = ptr_odd;

  // Outputs are decoded into their own flops alongside the state so that the
  // downstream display/UART logic sees glitch-free, registered signals.
  always_ff @(posedge clk_W or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      ptr_q   <= START_P;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort && state_q != S_IDLE) begin
      // Cancel wins over any pending transfer or transition.
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            ptr_q   <= START_P;
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          // The pair buffer captures A_in/B_in on this same edge.
          state_q <= S_SEND_A;
          valid_q <= 1'b1;
          idx_q   <= ptr_q;
        end
        S_SEND_A: begin
          if (dout_ready) begin
            state_q <= S_SEND_B;
            idx_q   <= ptr_odd;
          end
        end
        S_SEND_B: begin
          if (dout_ready) begin
            valid_q <= 1'b0;
            if (ptr_odd == END_P) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              ptr_q   <= ptr_d;
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  reg_pair_buf u_pair_buf (
    .clk_W  (clk_W),
    .rst_   (rst_),
    .load_i (state_q == S_FETCH),
    .sel_i  (state_q == S_SEND_B),
    .d0_i   (A_in),
    .d1_i   (B_in),
    .q_o    (dout_data)
  );

  assign dout_valid  = valid_q;
  assign dout_idx    = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader
//   Bench for reg_dump_reader: a behavioural register file, a full-range DUT
//   and a second DUT dumping only registers 28..31.
module tb_reg_dump_reader;

  localparam int W = 37;  // {idx[4:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk_W = 1'b0;
  logic rst_  = 1'b0;
  always #5 clk_W = ~clk_W;

  // ---------------- DUT signals ----------------
  logic        start = 1'b0, abort = 1'b0, dout_ready = 1'b1;
  logic [4:0]  A_addr, B_addr, dout_idx;
  logic [31:0] A_in, B_in, dout_data;
  logic        dout_valid, busy, done;
  logic [2:0]  dbg_state;

  logic        start2 = 1'b0, dout_ready2 = 1'b1;
  logic [4:0]  A_addr2, B_addr2, dout_idx2;
  logic [31:0] A_in2, B_in2, dout_data2;
  logic        dout_valid2, busy2, done2;
  logic [2:0]  dbg_state2;

  // ---------------- register file model ----------------
  logic [31:0] regs [32];
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd9;
  logic [31:0] wr_data = 32'h0;

  function automatic logic [31:0] reg_init(input int i);
    case (i)
      0:  return 32'h0000_0000;
      7:  return 32'h0000_0007;
      8:  return 32'hf7f7_f7f7;
      9:  return 32'h37f7_f7f7;
      29: return 32'h8000_0002;
      30: return 32'hffff_ffff;
      31: return 32'h7fff_ffff;
      default: return 32'h0000_0001;
    endcase
  endfunction

  always @(posedge clk_W or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 32; i++) regs[i] <= reg_init(i);
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign A_in  = regs[A_addr];
  assign B_in  = regs[B_addr];
  assign A_in2 = regs[A_addr2];
  assign B_in2 = regs[B_addr2];

  reg_dump_reader dut (
    .clk_W(clk_W), .rst_(rst_), .start(start), .abort(abort),
    .A_addr(A_addr), .B_addr(B_addr), .A_in(A_in), .B_in(B_in),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_idx(dout_idx),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  reg_dump_reader #(.START_REG(28), .END_REG(31)) dut2 (
    .clk_W(clk_W), .rst_(rst_), .start(start2), .abort(1'b0),
    .A_addr(A_addr2), .B_addr(B_addr2), .A_in(A_in2), .B_in(B_in2),
    .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .dout_data(dout_data2), .dout_idx(dout_idx2),
    .busy(busy2), .done(done2), .dbg_state_o(dbg_state2)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] got2_q[$];
  logic [31:0]  model_regs [32];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0, done2_cnt = 0, stall_viol = 0;
  bit prev_stall = 1'b0, prev_abort = 1'b0;
  logic [4:0]  prev_idx = '0;
  logic [31:0] prev_data = '0;

  // Output monitor: records every accepted word, done pulses and any change
  // of a stalled word. Sampled on the falling edge, between active edges.
  always @(negedge clk_W) begin
    if (!rst_) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_abort &&
          (!dout_valid || dout_idx !== prev_idx || dout_data !== prev_data))
        stall_viol++;
      if (dout_valid && dout_ready) got_q.push_back({dout_idx, dout_data});
      if (done) done_cnt++;
      prev_stall = dout_valid && !dout_ready;
      prev_idx   = dout_idx;
      prev_data  = dout_data;
      prev_abort = abort;
      if (dout_valid2 && dout_ready2) got2_q.push_back({dout_idx2, dout_data2});
      if (done2) done2_cnt++;
    end
  end

  // ---------------- reference model ----------------
  task automatic init_model();
    for (int i = 0; i < 32; i++) model_regs[i] = reg_init(i);
  endtask

  // Expected stream: every register in range, ascending, with the value
  // the file held when the dump began.
  task automatic build_exp(input int first, input int last);
    exp_q.delete();
    for (int i = first; i <= last; i++) exp_q.push_back({5'(i), model_regs[i]});
  endtask

  // ---------------- driver tasks ----------------
  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic start_dump();
    start = 1'b1;
    @(posedge clk_W); #1;
    start = 1'b0;
  endtask

  // Runs one dump on the main DUT until it is back in IDLE after done.
  task automatic run_dump(input bit rand_ready, input bit start_noise,
                          input int wr_cyc, output int done_cyc,
                          output int idle_cyc);
    done_cyc = 0;
    idle_cyc = 0;
    start_dump();
    for (int c = 1; c <= 1000; c++) begin
      if (done && done_cyc == 0) done_cyc = c;
      if (done_cyc != 0 && !busy && idle_cyc == 0) begin
        idle_cyc = c;
        break;
      end
      wr_en      = (c == wr_cyc);
      start      = (start_noise && done_cyc == 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk_W); #1;
    end
    wr_en = 1'b0; start = 1'b0; dout_ready = 1'b1;
    vectors++;
    if (idle_cyc == 0) begin
      miscompares++;
      $display("FAIL dump_timeout: got no return to idle within 1000 cycles, expected done then idle");
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [4:0] e5;
    vectors++; e5 = 5'd0;
    if (A_addr !== e5) begin miscompares++; $display("FAIL reset_A_addr: got %0d expected %0d", A_addr, e5); end
    vectors++; e5 = 5'd1;
    if (B_addr !== e5) begin miscompares++; $display("FAIL reset_B_addr: got %0d expected %0d", B_addr, e5); end
    vectors++; e5 = 5'd28;
    if (A_addr2 !== e5) begin miscompares++; $display("FAIL reset_A_addr2: got %0d expected %0d", A_addr2, e5); end
    vectors++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: got valid=%b busy=%b done=%b expected 0 0 0", dout_valid, busy, done);
    end
    vectors++;
    if (dout_data !== 32'h0 || dout_idx !== 5'd0) begin
      miscompares++; $display("FAIL reset_data: got %h/%0d expected 0/0", dout_data, dout_idx);
    end
  endtask

  task automatic test_full_dump();
    int base, dbase, dc, ic;
    init_model(); build_exp(0, 31);
    base = got_q.size(); dbase = done_cnt;
    run_dump(1'b0, 1'b0, 0, dc, ic);
    vectors++;
    if (got_q.size() - base != 32) begin miscompares++; $display("FAIL full_count: got %0d words expected 32", got_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin miscompares++; $display("FAIL full_word%0d: got %h expected %h", i, got_q[base+i], exp_q[i]); end
    end
    vectors++;
    if (dc != 49) begin miscompares++; $display("FAIL full_done_cycle: got %0d expected 49", dc); end
    vectors++;
    if (ic != 50) begin miscompares++; $display("FAIL full_idle_cycle: got %0d expected 50", ic); end
    vectors++;
    if (done_cnt - dbase != 1) begin miscompares++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt - dbase); end
  endtask

  task automatic test_random_ready();
    int base, sbase, dc, ic;
    init_model(); build_exp(0, 31);
    for (int rep = 0; rep < 2; rep++) begin
      base = got_q.size(); sbase = stall_viol;
      run_dump(1'b1, 1'b0, 0, dc, ic);
      vectors++;
      if (got_q.size() - base != 32) begin miscompares++; $display("FAIL rand_count: got %0d words expected 32", got_q.size() - base); end
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
        vectors++;
        if (got_q[base+i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_word%0d: got %h expected %h", i, got_q[base+i], exp_q[i]); end
      end
      vectors++;
      if (stall_viol != sbase) begin miscompares++; $display("FAIL rand_stall_stable: got %0d changes expected 0", stall_viol - sbase); end
    end
  endtask

  task automatic test_write_snapshot();
    int base, dc, ic;
    init_model(); build_exp(0, 31);
    wr_addr = 5'd9; wr_data = 32'h1234_5678;
    base = got_q.size();
    // Pair k occupies cycles 3k+1..3k+3; pair 8/9 is k=4, SEND_A in cycle 14.
    run_dump(1'b0, 1'b0, 14, dc, ic);
    vectors++;
    if (got_q.size() - base != 32) begin miscompares++; $display("FAIL snap_count: got %0d expected 32", got_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin miscompares++; $display("FAIL snap_old_word%0d: got %h expected %h", i, got_q[base+i], exp_q[i]); end
    end
    model_regs[9] = 32'h1234_5678; build_exp(0, 31);
    base = got_q.size();
    run_dump(1'b0, 1'b0, 0, dc, ic);
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin miscompares++; $display("FAIL snap_new_word%0d: got %h expected %h", i, got_q[base+i], exp_q[i]); end
    end
    // Put R9 back for the following scenarios.
    wr_data = 32'h37f7_f7f7; wr_en = 1'b1;
    @(posedge clk_W); #1;
    wr_en = 1'b0;
  endtask

  task automatic test_abort();
    int base, dbase, dc, ic;
    init_model(); build_exp(0, 31);
    base = got_q.size(); dbase = done_cnt;
    dout_ready = 1'b1;
    start_dump();
    // Pair 4/5 is k=2: SEND_B in cycle 9.
    for (int c = 1; c < 9; c++) begin @(posedge clk_W); #1; end
    vectors++;
    if (!(dout_valid === 1'b1 && dout_idx === 5'd5)) begin
      miscompares++; $display("FAIL abort_setup: got valid=%b idx=%0d expected 1/5", dout_valid, dout_idx);
    end
    abort = 1'b1; dout_ready = 1'b0;
    @(posedge clk_W); #1;
    abort = 1'b0; dout_ready = 1'b1;
    vectors++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL abort_idle: got valid=%b busy=%b done=%b expected 0 0 0", dout_valid, busy, done);
    end
    for (int c = 0; c < 5; c++) begin @(posedge clk_W); #1; end
    vectors++;
    if (done_cnt != dbase) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - dbase); end
    vectors++;
    if (got_q.size() - base != 5) begin miscompares++; $display("FAIL abort_count: got %0d words expected 5", got_q.size() - base); end
    for (int i = 0; i < 5 && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin miscompares++; $display("FAIL abort_word%0d: got %h expected %h", i, got_q[base+i], exp_q[i]); end
    end
    base = got_q.size();
    run_dump(1'b1, 1'b0, 0, dc, ic);
    vectors++;
    if (got_q.size() - base != 32) begin miscompares++; $display("FAIL restart_count: got %0d expected 32", got_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin miscompares++; $display("FAIL restart_word%0d: got %h expected %h", i, got_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base, dbase, dc, ic;
    init_model(); build_exp(0, 31);
    dbase = done_cnt;
    dout_ready = 1'b0;
    start_dump();
    start = 1'b1;  // held during busy; must be ignored
    @(posedge clk_W); #1;  // cycle 2: SEND_A, stalled
    vectors++;
    if (!(dout_valid === 1'b1 && dout_idx === 5'd0 && dout_data === model_regs[0])) begin
      miscompares++; $display("FAIL mid_first_word: got valid=%b idx=%0d data=%h expected 1/0/%h", dout_valid, dout_idx, dout_data, model_regs[0]);
    end
    @(posedge clk_W); #2;  // mid cycle 3, still stalled
    rst_ = 1'b0;
    #1;
    start = 1'b0;
    vectors++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_flags: got valid=%b busy=%b done=%b expected 0 0 0", dout_valid, busy, done);
    end
    vectors++;
    if (A_addr !== 5'd0 || B_addr !== 5'd1 || dout_idx !== 5'd0 || dout_data !== 32'h0) begin
      miscompares++; $display("FAIL mid_reset_values: got A=%0d B=%0d idx=%0d data=%h expected 0 1 0 0", A_addr, B_addr, dout_idx, dout_data);
    end
    @(posedge clk_W); #2;
    rst_ = 1'b1;
    @(posedge clk_W); #1;
    dout_ready = 1'b1;
    vectors++;
    if (done_cnt != dbase || busy !== 1'b0) begin
      miscompares++; $display("FAIL mid_no_done: got pulses=%0d busy=%b expected 0/0", done_cnt - dbase, busy);
    end
    base = got_q.size();
    run_dump(1'b1, 1'b1, 0, dc, ic);
    vectors++;
    if (got_q.size() - base != 32) begin miscompares++; $display("FAIL noise_count: got %0d expected 32", got_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      vectors++;
      if (got_q[base+i] !== exp_q[i]) begin miscompares++; $display("FAIL noise_word%0d: got %h expected %h", i, got_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_short_range();
    int base, dc;
    init_model(); build_exp(28, 31);
    base = got2_q.size(); dc = 0;
    dout_ready2 = 1'b1;
    start2 = 1'b1;
    @(posedge clk_W); #1;
    start2 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (done2 && dc == 0) dc = c;
      @(posedge clk_W); #1;
    end
    vectors++;
    if (dc != 7) begin miscompares++; $display("FAIL short_done_cycle: got %0d expected 7", dc); end
    vectors++;
    if (got2_q.size() - base != 4) begin miscompares++; $display("FAIL short_count: got %0d expected 4", got2_q.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < got2_q.size(); i++) begin
      vectors++;
      if (got2_q[base+i] !== exp_q[i]) begin miscompares++; $display("FAIL short_word%0d: got %h expected %h", i, got2_q[base+i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_ = 1'b0;
    repeat (2) @(posedge clk_W);
    #3 rst_ = 1'b1;
    @(posedge clk_W); #1;
    test_reset();
    test_full_dump();
    test_random_ready();
    test_write_snapshot();
    test_abort();
    test_reset_mid();
    test_short_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
